// File: rtl/pll_seq_pkg.sv
// Shared state encoding and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pll_seq_state_e;

    // Bits needed to hold 0..max_val without wrapping.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL LOCKED input.
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-debounce / staggered domain-release sequencer on the free-running reference clock.
// Optional PLL_SEQ_LOSS_CNT_EN adds o_loss_cnt, a saturating count of lock losses while running.
//
// state      | meaning
// RESET_PLL  | PLL held in reset for PLL_RST_CYCLES
// WAIT_LOCK  | waiting for synced lock, timeout counter running
// STABLE     | debouncing lock for LOCK_STABLE_CYCLES
// RELEASE    | releasing domain resets one by one, STAGGER_CYCLES apart
// RUN        | all domains out of reset, o_ready high
// FAULT      | too many lock timeouts, parked until force or reset
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 4,
    parameter int PLL_RST_CYCLES      = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGGER_CYCLES      = 16,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pll_locked,
    input  logic                   i_force_reseq,
    output logic                   o_pll_rst,
    output logic [NUM_DOMAINS-1:0] o_domain_rst_n,
    output logic                   o_ready,
    output logic                   o_fault,
    output logic [2:0]             o_state,
    output logic [7:0]             o_retry_cnt
`ifdef PLL_SEQ_LOSS_CNT_EN
    ,
    output logic [15:0]            o_loss_cnt
`endif
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_B   = (LOCK_TIMEOUT_CYCLES > STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = cnt_w(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    pll_seq_state_e          r_state;
    pll_seq_state_e          w_state_nx;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nx;
    logic [NUM_DOMAINS-1:0]  r_dom;
    logic [NUM_DOMAINS-1:0]  w_dom_nx;
    logic [7:0]              r_retry;
    logic [7:0]              w_retry_nx;
    logic [7:0]              w_retry_inc;
    logic                    r_pll_rst;
    logic                    r_ready;
    logic                    r_fault;
    logic                    w_lock_s;

    pll_lock_sync u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_locked),
        .o_q     (w_lock_s)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_dom_nx    = r_dom;
        w_retry_nx  = r_retry;
        w_retry_inc = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;

        if (i_force_reseq) begin
            w_state_nx = ST_RESET_PLL;
            w_cnt_nx   = '0;
            w_dom_nx   = '0;
            w_retry_nx = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    w_dom_nx = '0;
                    if (r_cnt == RST_LAST) begin
                        w_state_nx = ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        w_state_nx = ST_STABLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == TMO_LAST) begin
                        w_retry_nx = w_retry_inc;
                        w_cnt_nx   = '0;
                        w_state_nx = (w_retry_inc >= 8'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nx = ST_WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == STB_LAST) begin
                        w_state_nx = ST_RELEASE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // r_cnt is the stagger down-counter here; zero means release the next domain.
                    if (!w_lock_s) begin
                        w_state_nx = ST_RESET_PLL;
                        w_cnt_nx   = '0;
                        w_dom_nx   = '0;
                    end else if (r_dom[NUM_DOMAINS-1]) begin
                        w_state_nx = ST_RUN;
                        w_cnt_nx   = '0;
                        w_retry_nx = '0;
                    end else if (r_cnt == '0) begin
                        w_dom_nx = (r_dom << 1) | NUM_DOMAINS'(1);
                        w_cnt_nx = STG_LAST;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!w_lock_s) begin
                        w_state_nx = ST_RESET_PLL;
                        w_cnt_nx   = '0;
                        w_dom_nx   = '0;
                    end
                end
                ST_FAULT: begin
                    w_dom_nx = '0;
                end
                default: begin
                    w_state_nx = ST_RESET_PLL;
                    w_cnt_nx   = '0;
                    w_dom_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_RESET_PLL;
            r_cnt     <= '0;
            r_dom     <= '0;
            r_retry   <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_dom     <= w_dom_nx;
            r_retry   <= w_retry_nx;
            r_pll_rst <= (w_state_nx == ST_RESET_PLL) || (w_state_nx == ST_FAULT);
            r_ready   <= (w_state_nx == ST_RUN);
            r_fault   <= (w_state_nx == ST_FAULT);
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [15:0] r_loss_cnt;
    logic        w_loss_evt;

    // A force in the same cycle pre-empts the lock-loss transition, so it is not counted.
    assign w_loss_evt = (r_state == ST_RUN) && !w_lock_s && !i_force_reseq;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != 16'hFFFF)) begin
            r_loss_cnt <= r_loss_cnt + 16'd1;
        end
    end

    assign o_loss_cnt = r_loss_cnt;
`endif

    assign o_pll_rst      = r_pll_rst;
    assign o_domain_rst_n = r_dom;
    assign o_ready        = r_ready;
    assign o_fault        = r_fault;
    assign o_state        = r_state;
    assign o_retry_cnt    = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: a cycle-level model of the sequencing rules predicts every output change
// (value and cycle); a monitor compares each observed output change against the queue.
module tb_pll_reset_sequencer;

    localparam int ND   = 4;
    localparam int PRST = 4;
    localparam int STB  = 8;
    localparam int TMO  = 64;
    localparam int STG  = 2;
    localparam int MRT  = 2;

    logic          clk;
    logic          rst_n;
    logic          locked;
    logic          force_r;
    logic          pll_rst;
    logic [ND-1:0] dom;
    logic          ready;
    logic          fault;
    logic [2:0]    st;
    logic [7:0]    retry;
    logic [15:0]   mon_loss;

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic [15:0]   loss;
    assign mon_loss = loss;
`else
    assign mon_loss = 16'd0;
`endif

    pll_reset_sequencer #(
        .NUM_DOMAINS         (ND),
        .PLL_RST_CYCLES      (PRST),
        .LOCK_STABLE_CYCLES  (STB),
        .LOCK_TIMEOUT_CYCLES (TMO),
        .STAGGER_CYCLES      (STG),
        .MAX_RETRIES         (MRT)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_pll_locked   (locked),
        .i_force_reseq  (force_r),
        .o_pll_rst      (pll_rst),
        .o_domain_rst_n (dom),
        .o_ready        (ready),
        .o_fault        (fault),
        .o_state        (st),
        .o_retry_cnt    (retry)
`ifdef PLL_SEQ_LOSS_CNT_EN
        ,
        .o_loss_cnt     (loss)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [33:0] tup;
        int          stamp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: phase numbers follow the published state encoding; m_t counts cycles in phase.
    int          m_ph    = 0;
    int          m_t     = 0;
    int          m_retry = 0;
    int          m_rel   = 0;
    int          m_loss  = 0;
    bit          m_s1    = 0;
    bit          m_s2    = 0;
    bit          m_first = 1;
    logic [33:0] m_prev;

    function automatic logic [33:0] pack(logic [2:0] s, logic p, logic [3:0] d, logic r,
                                         logic f, logic [7:0] rt, logic [15:0] l);
        return {s, p, d, r, f, rt, l};
    endfunction

    function automatic string fmt(logic [33:0] t);
        return $sformatf("state=%0d pll_rst=%0b dom_rst_n=%b ready=%0b fault=%0b retry=%0d loss=%0d",
                         t[33:31], t[30], t[29:26], t[25], t[24], t[23:16], t[15:0]);
    endfunction

    function automatic logic [33:0] model_tup();
        logic [3:0]  d;
        logic [15:0] l;
        d = 4'((1 << m_rel) - 1);
`ifdef PLL_SEQ_LOSS_CNT_EN
        l = 16'(m_loss);
`else
        l = 16'd0;
`endif
        return pack(3'(m_ph), (m_ph == 0) || (m_ph == 5), d, m_ph == 4, m_ph == 5, 8'(m_retry), l);
    endfunction

    task automatic model_edge();
        bit          ls;
        logic [33:0] t;
        exp_t        e;
        int          r;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0;
            m_ph = 0; m_t = 0; m_retry = 0; m_rel = 0; m_loss = 0;
        end else if (force_r) begin
            m_ph = 0; m_t = 0; m_retry = 0; m_rel = 0;
        end else begin
            case (m_ph)
                0: if (m_t == PRST - 1) begin m_ph = 1; m_t = 0; end else m_t++;
                1: begin
                    if (ls) begin
                        m_ph = 2; m_t = 0;
                    end else if (m_t == TMO - 1) begin
                        m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                        m_ph    = (m_retry >= MRT) ? 5 : 0;
                        m_t     = 0;
                    end else m_t++;
                end
                2: begin
                    if (!ls) begin m_ph = 1; m_t = 0; end
                    else if (m_t == STB - 1) begin m_ph = 3; m_t = 0; end
                    else m_t++;
                end
                3: begin
                    if (!ls) begin
                        m_ph = 0; m_t = 0; m_rel = 0;
                    end else begin
                        m_t++;
                        if (m_t == (ND - 1) * STG + 2) begin
                            m_ph = 4; m_retry = 0; m_rel = ND;
                        end else begin
                            r     = (m_t - 1) / STG + 1;
                            m_rel = (r > ND) ? ND : r;
                        end
                    end
                end
                4: if (!ls) begin
                    m_ph = 0; m_t = 0; m_rel = 0;
                    if (m_loss < 65535) m_loss++;
                end
                default: ;
            endcase
        end
        t = model_tup();
        if (m_first || t !== m_prev) begin
            e.tup   = t;
            e.stamp = cyc + 1;
            sb_q.push_back(e);
            m_prev  = t;
            m_first = 0;
        end
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_force();
        force_r = 1'b1;
        step();
        force_r = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int budget);
        int n;
        n = 0;
        while (m_ph != ph && n < budget) begin step(); n++; end
        if (m_ph != ph) begin
            n_checks++; n_fail++;
            $display("FAIL wait_phase: phase=%0d required %0d within %0d cycles", m_ph, ph, budget);
        end
    endtask

    task automatic wait_rel(input int k, input int budget);
        int n;
        n = 0;
        while (m_rel < k && n < budget) begin step(); n++; end
        if (m_rel < k) begin
            n_checks++; n_fail++;
            $display("FAIL wait_rel: released=%0d required %0d within %0d cycles", m_rel, k, budget);
        end
    endtask

    // Monitor: every change of the observable outputs pops one expected change.
    logic [33:0] obs;
    logic [33:0] prev_obs;
    bit          mon_first = 1;
    exp_t        got_e;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                obs = pack(st, pll_rst, dom, ready, fault, retry, mon_loss);
                if (mon_first || obs !== prev_obs) begin
                    mon_first = 0;
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL out_change: cyc=%0d got %s ; required no change", cyc, fmt(obs));
                    end else begin
                        got_e = sb_q.pop_front();
                        if (got_e.tup !== obs || got_e.stamp != cyc) begin
                            n_fail++;
                            $display("FAIL out_change: cyc=%0d got %s ; required cyc=%0d %s",
                                     cyc, fmt(obs), got_e.stamp, fmt(got_e.tup));
                        end
                    end
                    n_checks++;
                    if ((((dom + 4'd1) & dom) != 4'd0) || $isunknown(dom)) begin
                        n_fail++;
                        $display("FAIL dom_order: cyc=%0d got dom_rst_n=%b ; required contiguous from bit 0", cyc, dom);
                    end
                    prev_obs = obs;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int r;

    initial begin
        rst_n   = 1'b0;
        locked  = 1'b0;
        force_r = 1'b0;
        hold(3);
        rst_n = 1'b1;

        // Nominal bring-up: lock 10 cycles after PLL reset falls.
        wait_phase(1, 20);
        hold(9);
        locked = 1'b1;
        hold(40);

        // Lock loss while running.
        locked = 1'b0;
        hold($urandom_range(1, 4));
        locked = 1'b1;
        hold(50);

        // Glitchy lock during debounce.
        locked = 1'b0;
        pulse_force();
        hold(12);
        locked = 1'b1;
        hold(5);
        locked = 1'b0;
        hold(2);
        locked = 1'b1;
        hold(40);

        // Repeated timeouts into FAULT, then force out of FAULT.
        locked = 1'b0;
        pulse_force();
        hold(2 * (PRST + TMO) + 10);
        locked = 1'b1;
        hold(5);
        pulse_force();
        hold(40);

        // Force after domain 1 has been released.
        pulse_force();
        wait_rel(2, 60);
        pulse_force();
        hold(40);

        // Reset pulse mid-release.
        pulse_force();
        wait_rel(1, 60);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        hold(40);

        // Randomized segments of lock level, forces and resets.
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else if (r < 3) begin
                pulse_force();
            end
            locked = 1'($urandom_range(0, 1));
            hold($urandom_range(1, 90));
        end
        locked = 1'b1;
        hold(60);

        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected changes ; required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
